numpad_scanner: RTL and testbench

//  Scans the 4x4 matrix keypad one column at a time and debounces the rows.

---
 rtl/numpad_scanner.sv | 175 +++++++++++++++++
 tb/tb_numpad_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/numpad_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, classifies each full
// scan frame and debounces it into a single one-cycle key code per press.
module numpad_scanner #(
    parameter int COL_CYCLES      = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] rows,
    output logic [3:0] columns,
    output logic [4:0] value,
    output logic       held
);

    localparam int SLOT_W = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(COL_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESS   = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Key-count encoding for the frame accumulator: 0, 1, or 2 meaning "two or more"
    localparam logic [1:0] N_NONE   = 2'd0;
    localparam logic [1:0] N_SINGLE = 2'd1;
    localparam logic [1:0] N_MULTI  = 2'd2;

    logic [3:0]        rows_s1_q, rows_s2_q;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        nkeys_q, nkeys_d;
    logic [3:0]        key_q, key_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        value_q, value_d;

    logic              slot_end, frame_end;
    logic [3:0]        closed;
    logic [1:0]        slot_n, slot_r;
    logic [1:0]        base_n, frame_n;
    logic [3:0]        base_key, frame_key;
    logic [CNT_W-1:0]  cnt_inc;
    logic              pulse;

    assign closed    = ~rows_s2_q;
    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (col_q == 2'd3);
    assign columns   = ~(4'b0001 << col_q);
    assign value     = value_q;
    assign held      = (state_q == HELD) || (state_q == RELEASE);
    assign cnt_inc   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        slot_n = N_NONE;
        slot_r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (closed[i]) begin
                slot_n = (slot_n == N_NONE) ? N_SINGLE : N_MULTI;
                slot_r = 2'(i);
            end
        end
    end

    // Column 0 starts a new frame, so the running tally is discarded there
    always_comb begin
        base_n   = (col_q == 2'd0) ? N_NONE : nkeys_q;
        base_key = (col_q == 2'd0) ? 4'd0 : key_q;
        if (slot_n == N_NONE)
            frame_n = base_n;
        else if (base_n == N_NONE)
            frame_n = slot_n;
        else
            frame_n = N_MULTI;
        frame_key = (slot_n == N_SINGLE) ? {col_q, slot_r} : base_key;
    end

    always_comb begin
        slot_d  = slot_end ? '0 : slot_q + SLOT_ONE;
        col_d   = slot_end ? col_q + 2'd1 : col_q;
        nkeys_d = slot_end ? frame_n : nkeys_q;
        key_d   = slot_end ? frame_key : key_q;
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        pulse   = 1'b0;
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (frame_n == N_SINGLE) begin
                        cand_d = frame_key;
                        cnt_d  = CNT_ONE;
                        if (CNT_ONE == CNT_DONE) begin
                            pulse   = 1'b1;
                            state_d = HELD;
                        end else begin
                            state_d = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (frame_n == N_SINGLE && frame_key == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            pulse   = 1'b1;
                            state_d = HELD;
                        end
                    end else if (frame_n == N_SINGLE) begin
                        cand_d = frame_key;
                        cnt_d  = CNT_ONE;
                    end else begin
                        cnt_d   = CNT_ZERO;
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (frame_n == N_NONE) begin
                        cnt_d   = CNT_ONE;
                        state_d = (CNT_ONE == CNT_DONE) ? IDLE : RELEASE;
                    end
                end
                default: begin
                    // A closed key seen during release is bounce: back to HELD, no new code
                    if (frame_n == N_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            cnt_d   = CNT_ZERO;
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d   = CNT_ZERO;
                        state_d = HELD;
                    end
                end
            endcase
        end
        value_d = pulse ? {1'b1, cand_d} : 5'b00000;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rows_s1_q <= '0;
            rows_s2_q <= '0;
            slot_q    <= '0;
            col_q     <= 2'd0;
            nkeys_q   <= N_NONE;
            key_q     <= 4'd0;
            state_q   <= IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= CNT_ZERO;
            value_q   <= 5'b00000;
        end else begin
            rows_s1_q <= rows;
            rows_s2_q <= rows_s1_q;
            slot_q    <= slot_d;
            col_q     <= col_d;
            nkeys_q   <= nkeys_d;
            key_q     <= key_d;
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
        end
    end

endmodule

// File: tb/tb_numpad_scanner.sv
// Bench for numpad_scanner: a keypad matrix model driven by directed and random
// key activity, checked cycle by cycle against a frame-level debounce model.
module tb_numpad_scanner;

    localparam int CC = 4;
    localparam int DF = 3;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  rows;
    logic [3:0]  columns;
    logic [4:0]  value;
    logic        held;
    logic [15:0] keys = 16'h0000;   // bit c*4+r = key at column c, row r closed

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [4:0] last_code = 5'b00000;

    // Reference model state
    int          k;
    int          pos, slot;
    int          fr_n, fr_key;
    int          run, cand;
    bit          down;
    logic [15:0] h0, h1, h2;
    logic [4:0]  exp_value;
    logic [3:0]  exp_cols;
    logic        exp_held;

    numpad_scanner #(.COL_CYCLES(CC), .DEBOUNCE_FRAMES(DF)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .rows    (rows),
        .columns (columns),
        .value   (value),
        .held    (held)
    );

    always #5 clock = ~clock;

    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !columns[c]) rows[r] = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Frame-level model: the sampled key set of column c at edge k is the key
    // state two edges earlier; debounce is tracked as a run length of frames.
    initial begin
        k = 0; down = 0; run = 0; cand = 0; fr_n = 0; fr_key = 0;
        h0 = '0; h1 = '0; h2 = '0;
        exp_value = '0; exp_cols = 4'b1110; exp_held = 1'b0;
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                k = 0; down = 0; run = 0; cand = 0; fr_n = 0;
                exp_value = '0; exp_cols = 4'b1110; exp_held = 1'b0;
            end else begin
                k++;
                h2 = h1; h1 = h0; h0 = keys;
                pos  = (k - 1) % CC;
                slot = ((k - 1) / CC) % 4;
                exp_value = '0;
                if (pos == CC - 1) begin
                    if (slot == 0) fr_n = 0;
                    for (int r = 0; r < 4; r++)
                        if (h2[slot*4+r]) begin
                            fr_n++;
                            fr_key = slot * 4 + r;
                        end
                    if (slot == 3) begin
                        if (!down) begin
                            if (fr_n == 1) begin
                                if (run > 0 && fr_key == cand) run++;
                                else begin
                                    run  = 1;
                                    cand = fr_key;
                                end
                                if (run >= DF) begin
                                    down = 1;
                                    run  = 0;
                                    exp_value = {1'b1, 4'(cand)};
                                end
                            end else run = 0;
                        end else begin
                            if (fr_n == 0) begin
                                run++;
                                if (run >= DF) begin
                                    down = 0;
                                    run  = 0;
                                end
                            end else run = 0;
                        end
                    end
                end
                exp_cols = ~(4'b0001 << ((k / CC) % 4));
                exp_held = down;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            check_val("value", value, exp_value);
            check_val("columns", columns, exp_cols);
            check_val("held", held, exp_held);
            if (value != 5'b00000) begin
                pulses++;
                last_code = value;
            end
        end
    end

    initial begin
        int base, mid, mode, dur, a, b;
        keys = 16'h0000;
        reset_n = 1'b0;
        wait_cyc(3);
        check_val("rst_value", value, 5'b00000);
        check_val("rst_columns", columns, 4'b1110);
        check_val("rst_held", held, 1'b0);
        reset_n = 1'b1;

        // No keys: plain sweep
        base = pulses;
        wait_cyc(64);
        check_val("idle_pulses", pulses - base, 0);

        // Clean hold of key 5
        base = pulses;
        keys = 16'h0020;
        wait_cyc(200);
        check_val("k5_held", held, 1'b1);
        keys = 16'h0000;
        wait_cyc(100);
        check_val("k5_pulses", pulses - base, 1);
        check_val("k5_code", last_code, 5'b10101);
        check_val("k5_released", held, 1'b0);

        // Bouncing key 7, then held
        base = pulses;
        keys = 16'h0004;
        repeat (16) begin
            wait_cyc(5);
            keys = keys ^ 16'h0004;
        end
        check_val("k7_bounce_pulses", pulses - base, 0);
        wait_cyc(100);
        check_val("k7_pulses", pulses - base, 1);
        check_val("k7_code", last_code, 5'b10010);
        keys = 16'h0000;
        wait_cyc(100);

        // Keys 1 and 2 together, then 2 released
        base = pulses;
        keys = 16'h0011;
        wait_cyc(100);
        check_val("k12_multi_pulses", pulses - base, 0);
        keys = 16'h0001;
        wait_cyc(100);
        check_val("k1_pulses", pulses - base, 1);
        check_val("k1_code", last_code, 5'b10000);
        keys = 16'h0000;
        wait_cyc(100);

        // Key B with a one-frame gap, then with a four-frame gap
        base = pulses;
        keys = 16'h2000; wait_cyc(80);
        keys = 16'h0000; wait_cyc(16);
        keys = 16'h2000; wait_cyc(80);
        keys = 16'h0000; wait_cyc(100);
        check_val("kB_short_gap_pulses", pulses - base, 1);
        check_val("kB_code", last_code, 5'b11101);
        base = pulses;
        keys = 16'h2000; wait_cyc(80);
        keys = 16'h0000; wait_cyc(64);
        keys = 16'h2000; wait_cyc(80);
        keys = 16'h0000; wait_cyc(100);
        check_val("kB_long_gap_pulses", pulses - base, 2);
        check_val("kB_code2", last_code, 5'b11101);

        // Reset in the middle of a press debounce (key 9)
        base = pulses;
        keys = 16'h0400;
        wait_cyc(24);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst_value", value, 5'b00000);
        check_val("midrst_columns", columns, 4'b1110);
        check_val("midrst_held", held, 1'b0);
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(40);
        mid = pulses;
        check_val("k9_early_pulses", mid - base, 0);
        wait_cyc(60);
        check_val("k9_pulses", pulses - base, 1);
        check_val("k9_code", last_code, 5'b11010);
        keys = 16'h0000;
        wait_cyc(100);

        // Random activity against the model
        repeat (60) begin
            mode = $urandom_range(0, 9);
            dur  = $urandom_range(8, 70);
            a    = $urandom_range(0, 15);
            b    = $urandom_range(0, 15);
            if (mode <= 5) begin
                keys = 16'h0000;
                keys[a] = 1'b1;
                wait_cyc(dur);
            end else if (mode == 6) begin
                keys = 16'h0000;
                wait_cyc(dur);
            end else if (mode == 7) begin
                keys = 16'h0000;
                keys[a] = 1'b1;
                keys[b] = 1'b1;
                wait_cyc(dur);
            end else begin
                keys = 16'h0000;
                repeat ($urandom_range(4, 14)) begin
                    keys[a] = ~keys[a];
                    wait_cyc($urandom_range(1, 6));
                end
            end
        end
        keys = 16'h0000;
        wait_cyc(100);
        check_val("final_held", held, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
